// File: rtl/his_builder_zoom_if.sv
// Bus between the rough-data front end and the zoom histogram builder.
// The master drives acquisition controls and the slave returns readout and result.
interface his_builder_zoom_if #(
    parameter int CB = 3,
    parameter int FB = 3,
    parameter int CW = 8
);
    localparam int IW = (CB > FB) ? CB : FB;

    logic              start;
    logic              wrEn;
    logic [CB+FB-1:0]  addr;
    logic              hisNum;
    logic              acq_count_finish;
    logic              bin_valid;
    logic [IW-1:0]     bin_idx;
    logic [CW-1:0]     binCounts;
    logic [CB-1:0]     peak_coarse;
    logic [FB-1:0]     peak_fine;
    logic [CB+FB-1:0]  tof;
    logic              hit;
    logic              result_valid;
    logic              overrun;

    modport master (
        output start, wrEn, addr,
        input  hisNum, acq_count_finish, bin_valid, bin_idx, binCounts,
               peak_coarse, peak_fine, tof, hit, result_valid, overrun
    );

    modport slave (
        input  start, wrEn, addr,
        output hisNum, acq_count_finish, bin_valid, bin_idx, binCounts,
               peak_coarse, peak_fine, tof, hit, result_valid, overrun
    );
endinterface

// File: rtl/his_builder_zoom.sv
// Two-pass coarse/fine histogram on TDC rough-data addresses: the coarse pass locates
// the peak region, and the fine pass resolves it. Both passes share one counter bank.
module his_builder_zoom #(
    parameter int CB    = 3,
    parameter int FB    = 3,
    parameter int CW    = 8,
    parameter int N_ACQ = 4
) (
    input  logic               clk,
    input  logic               res,
    his_builder_zoom_if.slave  bus
);
    localparam int IW = (CB > FB) ? CB : FB;
    localparam int NB = 1 << IW;
    localparam int AW = $clog2(N_ACQ + 1);
    localparam logic [IW:0] NBC = (IW+1)'(1 << CB);
    localparam logic [IW:0] NBF = (IW+1)'(1 << FB);

    typedef enum logic [2:0] {IDLE, ACQ_C, READ_C, ACQ_F, READ_F, DONE} state_t;

    state_t             state_q;
    logic [CW-1:0]      bins_q [NB];
    logic [AW-1:0]      acq_q;
    logic [IW:0]        rd_q;
    logic [CW-1:0]      max_q;
    logic [IW-1:0]      max_idx_q;
    logic               his_q, fin_q, bv_q, hit_q, rv_q, ovr_q;
    logic [IW-1:0]      bidx_q;
    logic [CW-1:0]      bcnt_q;
    logic [CB-1:0]      pc_q;
    logic [FB-1:0]      pf_q;
    logic [CB+FB-1:0]   tof_q;

    logic               in_acq, in_read, rd_en, wr_hit_d;
    logic [IW-1:0]      wr_idx_d, rd_idx;
    logic [IW:0]        n_bins;

    assign in_acq  = (state_q == ACQ_C) || (state_q == ACQ_F);
    assign in_read = (state_q == READ_C) || (state_q == READ_F);
    assign n_bins  = (state_q == READ_C) ? NBC : NBF;
    assign rd_idx  = rd_q[IW-1:0];
    assign rd_en   = in_read && (rd_q != n_bins);

    // Fine pass only accepts hits that fall inside the coarse peak region.
    always_comb begin
        wr_idx_d = '0;
        wr_hit_d = 1'b0;
        if (state_q == ACQ_C) begin
            wr_idx_d[CB-1:0] = bus.addr[CB+FB-1:FB];
            wr_hit_d = bus.wrEn && (bus.addr != '0);
        end else if (state_q == ACQ_F) begin
            wr_idx_d[FB-1:0] = bus.addr[FB-1:0];
            wr_hit_d = bus.wrEn && (bus.addr != '0) && (bus.addr[CB+FB-1:FB] == pc_q);
        end
    end

    // Saturating increment during acquisition, and clear-on-read during readout.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            for (int i = 0; i < NB; i++) bins_q[i] <= '0;
        end else if (wr_hit_d && (bins_q[wr_idx_d] != '1)) begin
            bins_q[wr_idx_d] <= bins_q[wr_idx_d] + 1'b1;
        end else if (rd_en) begin
            bins_q[rd_idx] <= '0;
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q   <= IDLE;
            acq_q     <= '0;
            rd_q      <= '0;
            max_q     <= '0;
            max_idx_q <= '0;
            his_q     <= 1'b0;
            fin_q     <= 1'b0;
            bv_q      <= 1'b0;
            bidx_q    <= '0;
            bcnt_q    <= '0;
            pc_q      <= '0;
            pf_q      <= '0;
            tof_q     <= '0;
            hit_q     <= 1'b0;
            rv_q      <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            fin_q <= 1'b0;
            bv_q  <= 1'b0;
            rv_q  <= 1'b0;
            if (bus.wrEn && !in_acq && (state_q != IDLE)) ovr_q <= 1'b1;
            case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state_q <= ACQ_C;
                        acq_q   <= '0;
                        ovr_q   <= 1'b0;
                        hit_q   <= 1'b0;
                        pc_q    <= '0;
                        pf_q    <= '0;
                        tof_q   <= '0;
                        his_q   <= 1'b0;
                    end
                end
                ACQ_C, ACQ_F: begin
                    if (bus.wrEn) begin
                        if (acq_q == AW'(N_ACQ - 1)) begin
                            acq_q     <= '0;
                            fin_q     <= 1'b1;
                            rd_q      <= '0;
                            max_q     <= '0;
                            max_idx_q <= '0;
                            state_q   <= (state_q == ACQ_C) ? READ_C : READ_F;
                        end else begin
                            acq_q <= acq_q + 1'b1;
                        end
                    end
                end
                READ_C, READ_F: begin
                    if (rd_q != n_bins) begin
                        bv_q   <= 1'b1;
                        bidx_q <= rd_idx;
                        bcnt_q <= bins_q[rd_idx];
                        // Strictly greater keeps the lowest index on ties.
                        if (bins_q[rd_idx] > max_q) begin
                            max_q     <= bins_q[rd_idx];
                            max_idx_q <= rd_idx;
                        end
                        rd_q <= rd_q + 1'b1;
                    end else if (state_q == READ_C) begin
                        pc_q <= max_idx_q[CB-1:0];
                        if (max_q != '0) begin
                            hit_q   <= 1'b1;
                            his_q   <= 1'b1;
                            acq_q   <= '0;
                            state_q <= ACQ_F;
                        end else begin
                            hit_q   <= 1'b0;
                            pf_q    <= '0;
                            tof_q   <= '0;
                            rv_q    <= 1'b1;
                            state_q <= DONE;
                        end
                    end else begin
                        pf_q    <= max_idx_q[FB-1:0];
                        tof_q   <= {pc_q, max_idx_q[FB-1:0]};
                        rv_q    <= 1'b1;
                        his_q   <= 1'b0;
                        state_q <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.hisNum           = his_q;
    assign bus.acq_count_finish = fin_q;
    assign bus.bin_valid        = bv_q;
    assign bus.bin_idx          = bidx_q;
    assign bus.binCounts        = bcnt_q;
    assign bus.peak_coarse      = pc_q;
    assign bus.peak_fine        = pf_q;
    assign bus.tof              = tof_q;
    assign bus.hit              = hit_q;
    assign bus.result_valid     = rv_q;
    assign bus.overrun          = ovr_q;
endmodule

// File: tb/tb_his_builder_zoom.sv
// Bench for his_builder_zoom: a vector table of fixed and random measurements checked
// against a counting model, plus overrun, reset-abort and saturation sequences.
module tb_his_builder_zoom;
    typedef logic [3:0][5:0] a4_t;
    typedef struct packed {
        a4_t        c;
        a4_t        f;
        logic [2:0] pc;
        logic [2:0] pf;
        logic [5:0] tof;
        logic       hit;
    } vec_t;

    localparam int NV = 9;

    logic clk = 1'b0;
    logic res = 1'b1;

    his_builder_zoom_if bus0 ();
    his_builder_zoom_if #(.CW(2)) bus1 ();

    his_builder_zoom dut0 (.clk(clk), .res(res), .bus(bus0));
    his_builder_zoom #(.CW(2), .N_ACQ(6)) dut1 (.clk(clk), .res(res), .bus(bus1));

    always #5 clk = ~clk;

    int   ncmp = 0;
    int   nfail = 0;
    int   gc[8], gf[8];
    int   ehc[8], ehf[8];
    logic [2:0] epc, epf;
    logic [5:0] etof;
    logic       ehit;
    vec_t tbl[NV];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic a4_t mk4(input logic [5:0] a, b, c, d);
        a4_t r;
        r[0] = a; r[1] = b; r[2] = c; r[3] = d;
        return r;
    endfunction

    // Reference: count hits per field, first maximum wins, fine pass gated on coarse peak.
    task automatic model(input a4_t c, input a4_t f);
        int mx;
        for (int i = 0; i < 8; i++) begin ehc[i] = 0; ehf[i] = 0; end
        for (int i = 0; i < 4; i++) if (c[i] != 0) ehc[c[i][5:3]]++;
        mx = 0; epc = 0;
        for (int i = 0; i < 8; i++) if (ehc[i] > mx) begin mx = ehc[i]; epc = 3'(i); end
        ehit = (mx > 0);
        epf = 0;
        if (ehit) begin
            for (int i = 0; i < 4; i++) if (f[i] != 0 && f[i][5:3] == epc) ehf[f[i][2:0]]++;
            mx = 0;
            for (int i = 0; i < 8; i++) if (ehf[i] > mx) begin mx = ehf[i]; epf = 3'(i); end
        end
        etof = ehit ? {epc, epf} : 6'd0;
    endtask

    task automatic pulse_start(input bit w);
        bus0.start = 1'b1; bus0.wrEn = w; bus0.addr = 6'd63;
        @(negedge clk);
        bus0.start = 1'b0; bus0.wrEn = 1'b0; bus0.addr = 6'd0;
    endtask

    task automatic write4(input a4_t a, input bit keep);
        for (int i = 0; i < 4; i++) begin
            bus0.wrEn = 1'b1; bus0.addr = a[i];
            @(negedge clk);
        end
        bus0.wrEn = keep;
    endtask

    // Capture readout strobes until the pass ends; n counts cycles since acq_count_finish.
    task automatic collect(input bit fine, output int n);
        n = 0;
        while (n < 40) begin
            if (bus0.bin_valid) begin
                if (bus0.hisNum) gf[bus0.bin_idx] = int'(bus0.binCounts);
                else             gc[bus0.bin_idx] = int'(bus0.binCounts);
            end
            if (bus0.result_valid || (!fine && bus0.hisNum)) break;
            n++;
            @(negedge clk);
        end
        if (n >= 40) begin
            ncmp++; nfail++;
            $display("FAIL collect_timeout: got no end of pass within 40 cycles");
        end
    endtask

    task automatic run_vec(input vec_t v, input bit w_at_start);
        int n;
        model(v.c, v.f);
        for (int i = 0; i < 8; i++) begin gc[i] = -1; gf[i] = -1; end
        pulse_start(w_at_start);
        chk("overrun_cleared", bus0.overrun, 0);
        chk("hit_cleared", bus0.hit, 0);
        write4(v.c, 1'b0);
        chk("acq_fin_c", bus0.acq_count_finish, 1);
        collect(1'b0, n);
        chk("lat_c", n, 9);
        if (ehit) begin
            chk("hisNum_f", bus0.hisNum, 1);
            write4(v.f, 1'b0);
            chk("acq_fin_f", bus0.acq_count_finish, 1);
            collect(1'b1, n);
            chk("lat_f", n, 9);
        end
        chk("result_valid", bus0.result_valid, 1);
        chk("hisNum_done", bus0.hisNum, 0);
        for (int i = 0; i < 8; i++) chk($sformatf("bin_c%0d", i), gc[i], ehc[i]);
        if (ehit) for (int i = 0; i < 8; i++) chk($sformatf("bin_f%0d", i), gf[i], ehf[i]);
        chk("peak_coarse", bus0.peak_coarse, v.pc);
        chk("peak_fine", bus0.peak_fine, v.pf);
        chk("tof", bus0.tof, v.tof);
        chk("hit", bus0.hit, v.hit);
        @(negedge clk);
        chk("result_pulse_once", bus0.result_valid, 0);
        chk("tof_held", bus0.tof, v.tof);
    endtask

    initial begin
        int n, b1;
        a4_t c, f;
        logic [2:0] lo;

        bus0.start = 0; bus0.wrEn = 0; bus0.addr = 0;
        bus1.start = 0; bus1.wrEn = 0; bus1.addr = 0;

        tbl[0] = '{c: mk4(9, 10, 12, 40), f: mk4(9, 12, 12, 50), pc: 1, pf: 4, tof: 12, hit: 1};
        tbl[1] = '{c: mk4(17, 17, 41, 41), f: mk4(17, 18, 18, 0), pc: 2, pf: 2, tof: 18, hit: 1};
        tbl[2] = '{c: mk4(0, 0, 0, 0), f: mk4(0, 0, 0, 0), pc: 0, pf: 0, tof: 0, hit: 0};
        for (int k = 3; k < NV; k++) begin
            for (int j = 0; j < 4; j++) begin
                c[j] = 6'($urandom_range(0, 63));
                if (j > 0 && $urandom_range(0, 2) == 0) c[j] = c[j-1];
            end
            model(c, mk4(0, 0, 0, 0));
            for (int j = 0; j < 4; j++) begin
                lo = 3'($urandom_range(0, 7));
                f[j] = ($urandom_range(0, 1) == 1) ? {epc, lo} : 6'($urandom_range(0, 63));
            end
            model(c, f);
            tbl[k] = '{c: c, f: f, pc: epc, pf: epf, tof: etof, hit: ehit};
        end

        @(negedge clk);
        @(negedge clk);
        chk("rst_hisNum", bus0.hisNum, 0);
        chk("rst_tof", bus0.tof, 0);
        chk("rst_bin_valid", bus0.bin_valid, 0);
        chk("rst_overrun", bus0.overrun, 0);
        res = 1'b0;
        @(negedge clk);

        // A write in IDLE is neither counted nor flagged.
        bus0.wrEn = 1'b1; bus0.addr = 6'd9;
        @(negedge clk);
        bus0.wrEn = 1'b0;
        chk("idle_wr_no_overrun", bus0.overrun, 0);

        for (int k = 0; k < NV; k++) run_vec(tbl[k], k == 0);

        // wrEn held through coarse readout must not disturb bins and must flag overrun.
        model(tbl[0].c, tbl[0].f);
        for (int i = 0; i < 8; i++) gc[i] = -1;
        pulse_start(1'b0);
        write4(tbl[0].c, 1'b1);
        collect(1'b0, n);
        bus0.wrEn = 1'b0;
        for (int i = 0; i < 8; i++) chk($sformatf("ovr_bin_c%0d", i), gc[i], ehc[i]);
        chk("overrun_set", bus0.overrun, 1);
        write4(tbl[0].f, 1'b0);
        collect(1'b1, n);
        chk("ovr_tof", bus0.tof, 12);
        chk("overrun_sticky", bus0.overrun, 1);
        run_vec(tbl[0], 1'b0);

        // Asynchronous reset in the middle of the fine pass.
        pulse_start(1'b0);
        write4(tbl[0].c, 1'b0);
        collect(1'b0, n);
        chk("abort_in_fine", bus0.hisNum, 1);
        bus0.wrEn = 1'b1; bus0.addr = 6'd9;
        @(negedge clk);
        bus0.addr = 6'd12;
        @(negedge clk);
        bus0.wrEn = 1'b0;
        #2 res = 1'b1;
        #1;
        chk("abort_hisNum", bus0.hisNum, 0);
        chk("abort_hit", bus0.hit, 0);
        chk("abort_peak_coarse", bus0.peak_coarse, 0);
        chk("abort_result_valid", bus0.result_valid, 0);
        res = 1'b0;
        @(negedge clk);
        run_vec(tbl[0], 1'b0);

        // Saturating counters on the narrow instance.
        b1 = -1;
        bus1.start = 1'b1;
        @(negedge clk);
        bus1.start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus1.wrEn = 1'b1; bus1.addr = 6'd8;
            @(negedge clk);
        end
        bus1.wrEn = 1'b0;
        chk("sat_acq_fin", bus1.acq_count_finish, 1);
        n = 0;
        while (n < 40 && !bus1.hisNum && !bus1.result_valid) begin
            if (bus1.bin_valid && bus1.bin_idx == 3'd1) b1 = int'(bus1.binCounts);
            n++;
            @(negedge clk);
        end
        chk("sat_bin1", b1, 3);
        chk("sat_hisNum", bus1.hisNum, 1);
        for (int i = 0; i < 6; i++) begin
            bus1.wrEn = 1'b1; bus1.addr = 6'd8;
            @(negedge clk);
        end
        bus1.wrEn = 1'b0;
        n = 0;
        while (n < 40 && !bus1.result_valid) begin
            n++;
            @(negedge clk);
        end
        chk("sat_result_valid", bus1.result_valid, 1);
        chk("sat_peak_coarse", bus1.peak_coarse, 1);
        chk("sat_tof", bus1.tof, 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
